wb_arbiter2: RTL

Two-master Wishbone arbiter that shares the single peripheral-bus slave port (LED/7-seg/switch/key/timer decoder) between the CPU data port and a second master (debug/DMA). It sits between the masters and the peripheral decoder, holds a grant for a whole Wishbone cycle, and terminates hung transfers with an error after a programmable timeout.

---
 rtl/wb_arbiter2.sv | 80 ++++++++
 1 files changed

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master Wishbone arbiter with per-cycle grant hold and slave timeout.
// Define WB_ARB_RR_EN for round-robin contention; otherwise master 0 has fixed priority.
module wb_arbiter2 #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);
  localparam logic [1:0] IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2;
  logic [1:0] state, state_nx, contend;
  logic last_gnt;
  logic [7:0] cnt;
  logic g0, g1, cyc, stb, tmo;
  assign g0 = state == GNT0;
  assign g1 = state == GNT1;
  assign cyc = (g0 & m0_cyc_i) | (g1 & m1_cyc_i);
  assign stb = (g0 & m0_cyc_i & m0_stb_i) | (g1 & m1_cyc_i & m1_stb_i);
  // an ack arriving on the timeout cycle takes precedence over the forced error
  assign tmo = stb & ~s_ack_i & (cnt == 8'(TIMEOUT - 1));
  assign s_cyc_o = cyc & ~tmo;
  assign s_stb_o = stb & ~tmo;
  assign s_we_o = g1 ? m1_we_i : g0 & m0_we_i;
  assign s_adr_o = g1 ? m1_adr_i : g0 ? m0_adr_i : '0;
  assign s_dat_o = g1 ? m1_dat_i : g0 ? m0_dat_i : '0;
  assign s_sel_o = g1 ? m1_sel_i : g0 ? m0_sel_i : '0;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = g0 & m0_cyc_i & s_ack_i;
  assign m1_ack_o = g1 & m1_cyc_i & s_ack_i;
  assign m0_err_o = g0 & tmo;
  assign m1_err_o = g1 & tmo;
  assign gnt_o = {g1, g0};
`ifdef WB_ARB_RR_EN
  assign contend = last_gnt ? GNT0 : GNT1;
`else
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
  assign contend = GNT0;
`endif
  always_comb
    state_nx = state == IDLE ? (m0_cyc_i & m1_cyc_i ? contend : m0_cyc_i ? GNT0 : m1_cyc_i ? GNT1 : IDLE)
             : (!cyc || tmo) ? IDLE : state;
  always_ff @(posedge wb_clk_i or negedge wb_rst_i)
    if (!wb_rst_i) begin
      state <= IDLE;
      last_gnt <= 1'b1;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx != IDLE) last_gnt <= state_nx == GNT1;
      cnt <= (!stb || s_ack_i || tmo) ? 8'd0 : cnt + 8'd1;
    end
endmodule
